// File: rtl/bp_update_ctrl_if.sv
// Resolved-branch update channel from AGEX into the predictor update controller.
// AGEX is the master; the controller is the slave and owns upd_ready.
interface bp_update_ctrl_if #(
  parameter int PT_INDEX_BITS  = 8,
  parameter int BTB_INDEX_BITS = 4,
  parameter int TAG_BITS       = 26,
  parameter int DBITS          = 32
);
  logic                      upd_valid;
  logic                      upd_ready;
  logic                      upd_taken;
  logic [PT_INDEX_BITS-1:0]  upd_pt_idx;
  logic [BTB_INDEX_BITS-1:0] upd_btb_idx;
  logic [TAG_BITS-1:0]       upd_tag;
  logic [DBITS-1:0]          upd_target;

  modport master (
    output upd_valid, upd_taken, upd_pt_idx, upd_btb_idx, upd_tag, upd_target,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_taken, upd_pt_idx, upd_btb_idx, upd_tag, upd_target,
    output upd_ready
  );
endinterface

// File: rtl/bp_update_ctrl.sv
// Branch predictor update sequencer: initialization walk over PT/BTB, then a
// small FIFO of resolved branches drained at one PT read-modify-write per cycle.
module bp_update_ctrl #(
  parameter int PT_INDEX_BITS  = 8,
  parameter int BTB_INDEX_BITS = 4,
  parameter int TAG_BITS       = 26,
  parameter int DBITS          = 32,
  parameter int BHR_BITS       = 8,
  parameter int QDEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reinit,
  bp_update_ctrl_if.slave              upd,
  output logic [PT_INDEX_BITS-1:0]     pt_rd_idx,
  input  logic [1:0]                   pt_rd_data,
  output logic                         pt_wr_en,
  output logic [PT_INDEX_BITS-1:0]     pt_wr_idx,
  output logic [1:0]                   pt_wr_data,
  output logic                         btb_wr_en,
  output logic [BTB_INDEX_BITS-1:0]    btb_wr_idx,
  output logic                         btb_wr_valid,
  output logic [TAG_BITS-1:0]          btb_wr_tag,
  output logic [DBITS-1:0]             btb_wr_target,
  output logic [BHR_BITS-1:0]          bhr,
  output logic                         pred_ready,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int PT_ENTRIES  = 1 << PT_INDEX_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int PTR_BITS    = $clog2(QDEPTH);
  localparam int CNT_BITS    = $clog2(QDEPTH + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic                      taken;
    logic [PT_INDEX_BITS-1:0]  pt_idx;
    logic [BTB_INDEX_BITS-1:0] btb_idx;
    logic [TAG_BITS-1:0]       tag;
    logic [DBITS-1:0]          target;
  } entry_t;

  state_t                  state_reg, state_next;
  logic [PT_INDEX_BITS:0]  init_idx_reg, init_idx_next;
  logic [BHR_BITS-1:0]     bhr_reg, bhr_next;
  logic                    pred_ready_reg, pred_ready_next;
  logic [PTR_BITS-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_BITS-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_BITS-1:0]     count_reg, count_next;

  entry_t queue_reg [QDEPTH];
  entry_t new_entry;
  entry_t head;
  logic   full, empty, push, pop;

  assign full      = (count_reg == CNT_BITS'(QDEPTH));
  assign empty     = (count_reg == '0);
  assign head      = queue_reg[rd_ptr_reg];
  assign new_entry = '{taken:   upd.upd_taken,
                       pt_idx:  upd.upd_pt_idx,
                       btb_idx: upd.upd_btb_idx,
                       tag:     upd.upd_tag,
                       target:  upd.upd_target};

  assign upd.upd_ready = !reset && !full;
  assign push          = upd.upd_valid && !full && !reinit;

  assign bhr        = bhr_reg;
  assign pred_ready = pred_ready_reg;
  assign q_count    = count_reg;

  // Queue payload needs no reset; occupancy is tracked by the pointers/count.
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_queue
      always_ff @(posedge clk) begin
        if (push && wr_ptr_reg == PTR_BITS'(gi)) begin
          queue_reg[gi] <= new_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_INIT;
      init_idx_reg   <= '0;
      bhr_reg        <= '0;
      pred_ready_reg <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      init_idx_reg   <= init_idx_next;
      bhr_reg        <= bhr_next;
      pred_ready_reg <= pred_ready_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    init_idx_next   = init_idx_reg;
    bhr_next        = bhr_reg;
    pred_ready_next = pred_ready_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    count_next      = count_reg;
    pop             = 1'b0;
    pt_rd_idx       = '0;
    pt_wr_en        = 1'b0;
    pt_wr_idx       = '0;
    pt_wr_data      = '0;
    btb_wr_en       = 1'b0;
    btb_wr_idx      = '0;
    btb_wr_valid    = 1'b0;
    btb_wr_tag      = '0;
    btb_wr_target   = '0;

    if (reinit) begin
      // Restart wins over everything: flush queue, drop the push, no writes.
      state_next      = ST_INIT;
      init_idx_next   = '0;
      bhr_next        = '0;
      pred_ready_next = 1'b0;
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      count_next      = '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          pt_wr_en   = !reset;
          pt_wr_idx  = init_idx_reg[PT_INDEX_BITS-1:0];
          pt_wr_data = 2'b01;
          if (init_idx_reg < (PT_INDEX_BITS+1)'(BTB_ENTRIES)) begin
            btb_wr_en  = !reset;
            btb_wr_idx = init_idx_reg[BTB_INDEX_BITS-1:0];
          end
          init_idx_next = init_idx_reg + 1'b1;
          if (init_idx_reg == (PT_INDEX_BITS+1)'(PT_ENTRIES - 1)) begin
            state_next      = ST_RUN;
            pred_ready_next = 1'b1;
          end
        end
        ST_RUN: begin
          if (!empty) begin
            pop        = 1'b1;
            pt_rd_idx  = head.pt_idx;
            pt_wr_en   = !reset;
            pt_wr_idx  = head.pt_idx;
            if (head.taken)
              pt_wr_data = (pt_rd_data == 2'b11) ? 2'b11 : pt_rd_data + 2'b01;
            else
              pt_wr_data = (pt_rd_data == 2'b00) ? 2'b00 : pt_rd_data - 2'b01;
            if (head.taken) begin
              btb_wr_en     = !reset;
              btb_wr_idx    = head.btb_idx;
              btb_wr_valid  = 1'b1;
              btb_wr_tag    = head.tag;
              btb_wr_target = head.target;
            end
            bhr_next = {bhr_reg[BHR_BITS-2:0], head.taken};
          end
        end
        default: state_next = ST_INIT;
      endcase

      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: a PT array model feeds pt_rd_data, a
// reference PT predicts each write at push time, pops are checked at negedge.
module tb_bp_update_ctrl;

  localparam int PTB = 8, BTBB = 4, TAGB = 26, DB = 32, BHRB = 8, QD = 4;

  logic clk = 1'b0;
  logic reset, reinit;
  logic [PTB-1:0]  pt_rd_idx, pt_wr_idx;
  logic [1:0]      pt_rd_data, pt_wr_data;
  logic            pt_wr_en, btb_wr_en, btb_wr_valid, pred_ready;
  logic [BTBB-1:0] btb_wr_idx;
  logic [TAGB-1:0] btb_wr_tag;
  logic [DB-1:0]   btb_wr_target;
  logic [BHRB-1:0] bhr;
  logic [2:0]      q_count;

  bp_update_ctrl_if #(.PT_INDEX_BITS(PTB), .BTB_INDEX_BITS(BTBB),
                      .TAG_BITS(TAGB), .DBITS(DB)) upd_if ();

  bp_update_ctrl #(.PT_INDEX_BITS(PTB), .BTB_INDEX_BITS(BTBB), .TAG_BITS(TAGB),
                   .DBITS(DB), .BHR_BITS(BHRB), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset), .reinit(reinit), .upd(upd_if.slave),
    .pt_rd_idx(pt_rd_idx), .pt_rd_data(pt_rd_data),
    .pt_wr_en(pt_wr_en), .pt_wr_idx(pt_wr_idx), .pt_wr_data(pt_wr_data),
    .btb_wr_en(btb_wr_en), .btb_wr_idx(btb_wr_idx), .btb_wr_valid(btb_wr_valid),
    .btb_wr_tag(btb_wr_tag), .btb_wr_target(btb_wr_target),
    .bhr(bhr), .pred_ready(pred_ready), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PTB-1:0]  pt_idx;
    logic [1:0]      data;
    logic            taken;
    logic [BTBB-1:0] btb_idx;
    logic [TAGB-1:0] tag;
    logic [DB-1:0]   target;
    logic [BHRB-1:0] bhr_before;
  } exp_t;

  exp_t            exp_q[$];
  logic [1:0]      pt_mem [256];
  logic [1:0]      pt_ref [256];
  logic [BHRB-1:0] bhr_ref;
  int              checks = 0, errors = 0;
  int              init_cnt = 0;
  logic            prev_pr = 1'b0;
  logic            reinit_cyc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  assign pt_rd_data = pt_mem[pt_rd_idx];
  always @(posedge clk) if (pt_wr_en) pt_mem[pt_wr_idx] <= pt_wr_data;

  // Monitor: walk writes while !pred_ready, scoreboard pops while pred_ready.
  always @(negedge clk) begin
    if (reset) begin
      init_cnt = 0;
      prev_pr  = 1'b0;
    end else if (!reinit_cyc) begin
      if (pred_ready && !prev_pr) chk("walk_len", init_cnt, 256);
      prev_pr = pred_ready;
      if (!pred_ready) begin
        chk("init_en", pt_wr_en, 1);
        chk("init_idx", pt_wr_idx, init_cnt[7:0]);
        chk("init_data", pt_wr_data, 2'b01);
        chk("init_btb_en", btb_wr_en, init_cnt < 16);
        if (btb_wr_en) begin
          chk("init_btb_idx", btb_wr_idx, init_cnt[3:0]);
          chk("init_btb_fields", {btb_wr_valid, btb_wr_tag, btb_wr_target}, 0);
        end
        init_cnt++;
      end else if (pt_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexp_wr", pt_wr_en, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("pop  idx=%0d data=%0d taken=%0d btb_en=%0d bhr=%0h",
                   pt_wr_idx, pt_wr_data, e.taken, btb_wr_en, bhr);
          chk("pop_rd_idx", pt_rd_idx, e.pt_idx);
          chk("pop_wr_idx", pt_wr_idx, e.pt_idx);
          chk("pop_wr_data", pt_wr_data, e.data);
          chk("pop_btb_en", btb_wr_en, e.taken);
          chk("pop_bhr", bhr, e.bhr_before);
          if (e.taken) begin
            chk("pop_btb_idx", btb_wr_idx, e.btb_idx);
            chk("pop_btb_valid", btb_wr_valid, 1);
            chk("pop_btb_tag", btb_wr_tag, e.tag);
            chk("pop_btb_target", btb_wr_target, e.target);
          end
        end
      end else begin
        chk("idle_btb_en", btb_wr_en, 0);
      end
    end
  end

  // Drive one update for one cycle (called at posedge+1); records expectation if accepted.
  task automatic push(input logic tk, input logic [PTB-1:0] pi, input logic [BTBB-1:0] bi,
                      input logic [TAGB-1:0] tg, input logic [DB-1:0] tgt);
    exp_t e;
    upd_if.upd_valid   = 1'b1;
    upd_if.upd_taken   = tk;
    upd_if.upd_pt_idx  = pi;
    upd_if.upd_btb_idx = bi;
    upd_if.upd_tag     = tg;
    upd_if.upd_target  = tgt;
    if (upd_if.upd_ready) begin
      e.pt_idx  = pi;
      e.taken   = tk;
      e.btb_idx = bi;
      e.tag     = tg;
      e.target  = tgt;
      if (tk) e.data = (pt_ref[pi] == 2'd3) ? 2'd3 : pt_ref[pi] + 2'd1;
      else    e.data = (pt_ref[pi] == 2'd0) ? 2'd0 : pt_ref[pi] - 2'd1;
      pt_ref[pi]   = e.data;
      e.bhr_before = bhr_ref;
      bhr_ref      = {bhr_ref[BHRB-2:0], tk};
      exp_q.push_back(e);
      $display("push idx=%0d taken=%0d btb=%0d tag=%0h tgt=%0h", pi, tk, bi, tg, tgt);
    end else begin
      $display("push idx=%0d refused (queue full)", pi);
    end
    @(posedge clk); #1;
    upd_if.upd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!pred_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pred_ready_timeout", pred_ready, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    chk("drain_qcount", q_count, 0);
  endtask

  task automatic reset_refs();
    for (int i = 0; i < 256; i++) pt_ref[i] = 2'b01;
    bhr_ref = '0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    reinit = 1'b0;
    upd_if.upd_valid = 1'b0;
    upd_if.upd_taken = 1'b0;
    upd_if.upd_pt_idx = '0;
    upd_if.upd_btb_idx = '0;
    upd_if.upd_tag = '0;
    upd_if.upd_target = '0;
    for (int i = 0; i < 256; i++) pt_mem[i] = 2'b00;
    reset_refs();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pt_wr_en", pt_wr_en, 0);
    chk("rst_btb_wr_en", btb_wr_en, 0);
    chk("rst_upd_ready", upd_if.upd_ready, 0);
    chk("rst_pred_ready", pred_ready, 0);
    chk("rst_bhr", bhr, 0);
    chk("rst_qcount", q_count, 0);
    reset = 1'b0;

    // Reset mid-walk: outputs drop immediately, walk restarts at 0.
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_pt_wr_en", pt_wr_en, 0);
    chk("midrst_upd_ready", upd_if.upd_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill the queue during INIT; the fifth update is refused.
    @(posedge clk); #1;
    push(1'b1, 8'd20, 4'd1, 26'h0AAAA, 32'h1000);
    push(1'b0, 8'd21, 4'd2, 26'h0BBBB, 32'h2000);
    push(1'b1, 8'd20, 4'd1, 26'h0CCCC, 32'h3000);
    push(1'b1, 8'd22, 4'd5, 26'h0DDDD, 32'h4000);
    chk("init_qcount_full", q_count, 4);
    chk("init_ready_full", upd_if.upd_ready, 0);
    push(1'b1, 8'd23, 4'd6, 26'h0EEEE, 32'h5000);
    chk("fifth_dropped_qcount", q_count, 4);
    wait_ready();
    wait_drain();
    chk("bhr_after_drain", bhr, bhr_ref);
    chk("idle_rd_idx", pt_rd_idx, 0);

    // Basic taken update.
    push(1'b1, 8'd5, 4'd3, 26'h1234, 32'h100);
    wait_drain();
    chk("bhr_after_taken", bhr, bhr_ref);

    // Saturation at both ends.
    pt_mem[9] = 2'd3;  pt_ref[9] = 2'd3;
    pt_mem[10] = 2'd0; pt_ref[10] = 2'd0;
    push(1'b1, 8'd9, 4'd7, 26'h2222, 32'h200);
    push(1'b0, 8'd10, 4'd8, 26'h3333, 32'h300);
    wait_drain();
    chk("bhr_after_sat", bhr, bhr_ref);

    // Back-to-back updates to one PT entry see the previous write.
    pt_mem[7] = 2'd0; pt_ref[7] = 2'd0;
    push(1'b1, 8'd7, 4'd9, 26'h4444, 32'h400);
    push(1'b1, 8'd7, 4'd9, 26'h5555, 32'h500);
    wait_drain();
    chk("b2b_final_pt", pt_mem[7], 2'd2);

    // Reinit from idle RUN restarts the walk.
    reinit = 1'b1;
    reinit_cyc = 1'b1;
    @(negedge clk);
    chk("reinit0_nowr", {pt_wr_en, btb_wr_en}, 0);
    @(posedge clk); #1;
    reinit = 1'b0;
    reinit_cyc = 1'b0;
    init_cnt = 0;
    reset_refs();
    chk("reinit0_pred_ready", pred_ready, 0);

    // Queue four during the new walk, reinit with three still queued.
    push(1'b1, 8'd30, 4'd1, 26'h6666, 32'h600);
    push(1'b1, 8'd31, 4'd2, 26'h7777, 32'h700);
    push(1'b0, 8'd32, 4'd3, 26'h8888, 32'h800);
    push(1'b1, 8'd33, 4'd4, 26'h9999, 32'h900);
    wait_ready();
    @(posedge clk); #1;
    chk("pre_reinit_qcount", q_count, 3);
    reinit = 1'b1;
    reinit_cyc = 1'b1;
    upd_if.upd_valid = 1'b1;
    upd_if.upd_taken = 1'b1;
    upd_if.upd_pt_idx = 8'd40;
    @(negedge clk);
    chk("reinit_nowr", {pt_wr_en, btb_wr_en}, 0);
    @(posedge clk); #1;
    reinit = 1'b0;
    reinit_cyc = 1'b0;
    upd_if.upd_valid = 1'b0;
    init_cnt = 0;
    reset_refs();
    chk("reinit_qcount", q_count, 0);
    chk("reinit_bhr", bhr, 0);
    chk("reinit_pred_ready", pred_ready, 0);
    wait_ready();
    chk("post_walk_qcount", q_count, 0);
    push(1'b0, 8'd50, 4'd0, 26'h1, 32'h4);
    wait_drain();
    chk("final_bhr", bhr, bhr_ref);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Sequences all writes into the branch predictor state: the global branch history register (BHR), the 2-bit pattern table (PT) and the branch target buffer (BTB).
- Sits between the AGEX stage (producer of resolved-branch updates) and the PT/BTB storage arrays (consumer of write commands).
- After reset or a reinit request, walks every table entry to a known state, then drains a small update queue at one read-modify-write per cycle.
- Exports BHR and a predictor-ready flag to FE; FE predicts not-taken while `pred_ready` = 0.

Parameters:
- PT_INDEX_BITS, 8, PT index width; PT has 2^PT_INDEX_BITS entries.
- BTB_INDEX_BITS, 4, BTB index width; must be <= PT_INDEX_BITS.
- TAG_BITS, 26, BTB tag width.
- DBITS, 32, target address width.
- BHR_BITS, 8, history register width.
- QDEPTH, 4, update queue depth; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- reinit  in  1  synchronous request to restart the initialization walk.
- upd_valid  in  1  AGEX presents a resolved branch/jump.
- upd_ready  out  1  queue can accept this cycle.
- upd_taken  in  1  actual direction.
- upd_pt_idx  in  PT_INDEX_BITS  PT index used at prediction.
- upd_btb_idx  in  BTB_INDEX_BITS  BTB index.
- upd_tag  in  TAG_BITS  PC tag.
- upd_target  in  DBITS  resolved target.
- pt_rd_idx  out  PT_INDEX_BITS  combinational read address into PT.
- pt_rd_data  in  2  combinational PT read data for pt_rd_idx.
- pt_wr_en  out  1  PT write strobe.
- pt_wr_idx  out  PT_INDEX_BITS  PT write address.
- pt_wr_data  out  2  PT write data.
- btb_wr_en  out  1  BTB write strobe.
- btb_wr_idx  out  BTB_INDEX_BITS  BTB write address.
- btb_wr_valid  out  1  BTB valid bit to write.
- btb_wr_tag  out  TAG_BITS  BTB tag to write.
- btb_wr_target  out  DBITS  BTB target to write.
- bhr  out  BHR_BITS  current global history.
- pred_ready  out  1  tables initialized; FE may use predictions.
- q_count  out  clog2(QDEPTH+1)  current queue occupancy.

Behaviour:
- Reset values: state=INIT, init_idx=0, queue empty, q_count=0, bhr=0, pred_ready=0.
- Outputs `upd_ready` and the write strobes are combinational from state and queue; they are 0 while reset is asserted.
- State INIT, per cycle:
  - pt_wr_en=1, pt_wr_idx=init_idx, pt_wr_data=2'b01 (weakly not-taken).
  - If init_idx < 2^BTB_INDEX_BITS: btb_wr_en=1, btb_wr_idx=init_idx[BTB_INDEX_BITS-1:0], btb_wr_valid=0, tag and target 0.
  - init_idx increments each cycle.
  - When init_idx = 2^PT_INDEX_BITS-1, the next state is RUN.
  - The walk takes exactly 2^PT_INDEX_BITS cycles; pred_ready rises on the edge that enters RUN.
  - The queue is not popped during INIT.
- State RUN:
  - pred_ready=1.
  - If the queue is not empty, pop the head entry in the same cycle:
    - pt_rd_idx = head.pt_idx.
    - pt_wr_en=1, pt_wr_idx = head.pt_idx.
    - pt_wr_data = taken ? sat_inc(pt_rd_data) : sat_dec(pt_rd_data), saturating at 3 and 0.
    - If head.taken: btb_wr_en=1 with valid=1, head tag, head target. If not taken, no BTB write.
    - bhr <= {bhr[BHR_BITS-2:0], head.taken}.
  - If the queue is empty, no writes occur and pt_rd_idx=0.
- Queue:
  - upd_ready = !full in both states.
  - Push when upd_valid && upd_ready.
  - Push and pop in the same cycle are both honoured; q_count is unchanged.
  - No bypass: an entry pushed at edge N is popped no earlier than the cycle after edge N.
  - Ordering is strictly FIFO.
  - Consecutive pops to the same pt_idx see the previous write, because the array commits at the edge.
- reinit (sampled in any state) has priority over pop and push that cycle. At the next edge:
  - The queue is flushed and the push is dropped.
  - bhr=0, init_idx=0, pred_ready=0, state=INIT.
  - No PT/BTB write is issued in the reinit cycle.
- Asynchronous reset mid-walk or mid-pop: all state returns to its reset values immediately; a partially walked table is rewalked from index 0.
- Widths: init_idx is PT_INDEX_BITS+1 bits internally so it cannot wrap; all pointers wrap modulo QDEPTH.

Test Plan:
- Reset release -> pt_wr_en=1 with data 01 for idx 0..255 on 256 consecutive cycles, btb_wr_en=1 valid=0 for idx 0..15 only, pred_ready=1 after cycle 256, bhr=0.
- RUN, push {taken=1, pt_idx=5, btb_idx=3, tag=0x1234, target=0x100}, model pt_rd_data=01 -> next cycle pt_wr idx 5 data 10, btb_wr idx 3 valid=1 tag 0x1234 target 0x100, bhr becomes 0x01.
- Saturation: taken with pt_rd_data=3 -> write 3; not-taken with pt_rd_data=0 -> write 0, btb_wr_en=0, bhr shifts in 0.
- During INIT, push 4 updates -> q_count=4, upd_ready=0, 5th valid ignored. After INIT, entries drain one per cycle in push order over 4 cycles, then q_count=0.
- Two back-to-back taken updates to pt_idx 7 with the array model starting at 00 -> writes 01 then 10.
- RUN with 3 queued entries, assert reinit together with upd_valid -> q_count=0 and bhr=0 next cycle, no writes in the reinit cycle, full 256-cycle walk repeats.
